// File: rtl/id_issue_ctrl.sv
// Decode/issue holding register between fetch and execute.
// Holds one instruction, detects load-use hazards and counts bubbles.
module id_issue_ctrl #(
    parameter logic [4:0] IMM_I_CODE = 5'd1,
    parameter logic [4:0] IMM_S_CODE = 5'd2,
    parameter logic [4:0] IMM_B_CODE = 5'd3,
    parameter logic [4:0] IMM_J_CODE = 5'd4,
    parameter logic [4:0] IMM_U_CODE = 5'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        ex_ready,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [4:0]  imm_sel,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [15:0] stall_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] cnt_q, cnt_d;

    logic        full;
    logic [4:0]  imm_raw;
    logic        use_rs1;
    logic        use_rs2;
    logic        hazard;
    logic        id_fire;
    logic        if_fire;

    assign full = (state_q == FULL);

    always_comb begin
        imm_raw = 5'd0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (instr_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                imm_raw = IMM_I_CODE;
                use_rs1 = 1'b1;
            end
            7'b0100011: begin
                imm_raw = IMM_S_CODE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b1100011: begin
                imm_raw = IMM_B_CODE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b1101111: imm_raw = IMM_J_CODE;
            7'b0110111, 7'b0010111: imm_raw = IMM_U_CODE;
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // x0 never carries a loaded value, so a load to x0 cannot create a hazard
    assign hazard = full && ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (instr_q[19:15] == ex_rd)) ||
                     (use_rs2 && (instr_q[24:20] == ex_rd)));

    assign id_valid = full && !hazard && !flush;
    assign id_fire  = id_valid && ex_ready;
    assign if_ready = rst_n && (!full || id_fire);
    assign if_fire  = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Leaving FULL clears the payload so EMPTY always reads as zero
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            state_d = EMPTY;
            instr_d = '0;
            pc_d    = '0;
        end else if (if_fire) begin
            state_d = FULL;
            instr_d = if_instr;
            pc_d    = if_pc;
        end else if (id_fire) begin
            state_d = EMPTY;
            instr_d = '0;
            pc_d    = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !flush && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        id_instr  = full ? instr_q : 32'd0;
        id_pc     = full ? pc_q : 32'd0;
        imm_sel   = full ? imm_raw : 5'd0;
        id_rs1    = full ? instr_q[19:15] : 5'd0;
        id_rs2    = full ? instr_q[24:20] : 5'd0;
        id_rd     = full ? instr_q[11:7] : 5'd0;
        stall_cnt = cnt_q;
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed and random stimulus for id_issue_ctrl against an
// instruction-slot reference model.
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        ex_ready;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  imm_sel;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [15:0] stall_cnt;

    id_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .ex_ready   (ex_ready),
        .ex_mem_read(ex_mem_read),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .imm_sel    (imm_sel),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit quiet = 1'b0;

    // reference slot: an optional (instr, pc) pair plus the bubble count
    bit          m_full;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int          m_cnt;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LUI  = 32'h123450B7;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] m_imm(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return 5'd1;
            7'h23: return 5'd2;
            7'h63: return 5'd3;
            7'h6F: return 5'd4;
            7'h37, 7'h17: return 5'd5;
            default: return 5'd0;
        endcase
    endfunction

    function automatic bit reads1(input logic [31:0] i);
        return i[6:0] inside {7'h13, 7'h03, 7'h67, 7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit reads2(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit m_hazard();
        if (!m_full || !ex_mem_read || ex_rd == 5'd0) return 1'b0;
        return (reads1(m_instr) && m_instr[19:15] == ex_rd) ||
               (reads2(m_instr) && m_instr[24:20] == ex_rd);
    endfunction

    function automatic bit m_issue();
        return m_full && !m_hazard() && !flush;
    endfunction

    function automatic bit m_accept();
        return rst_n && (!m_full || (m_issue() && ex_ready));
    endfunction

    task automatic model_check();
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_issue()});
        chk("if_ready", {31'd0, if_ready}, {31'd0, m_accept()});
        chk("id_instr", id_instr, m_full ? m_instr : 32'd0);
        chk("id_pc", id_pc, m_full ? m_pc : 32'd0);
        chk("imm_sel", {27'd0, imm_sel}, m_full ? {27'd0, m_imm(m_instr)} : 32'd0);
        chk("id_rs1", {27'd0, id_rs1}, m_full ? {27'd0, m_instr[19:15]} : 32'd0);
        chk("id_rs2", {27'd0, id_rs2}, m_full ? {27'd0, m_instr[24:20]} : 32'd0);
        chk("id_rd", {27'd0, id_rd}, m_full ? {27'd0, m_instr[11:7]} : 32'd0);
        chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
    endtask

    task automatic model_edge();
        bit hz, issue, take;
        hz    = m_hazard();
        issue = m_issue() && ex_ready;
        take  = if_valid && m_accept();
        if (!rst_n) begin
            m_full = 1'b0;
            m_cnt  = 0;
        end else begin
            if (hz && !flush && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (flush) m_full = 1'b0;
            else if (take) begin
                m_full  = 1'b1;
                m_instr = if_instr;
                m_pc    = if_pc;
            end else if (issue) m_full = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!quiet) model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] ops [10];
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                7'h6F, 7'h37, 7'h17, 7'h33, 7'h73};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        m_full = 1'b0; m_instr = '0; m_pc = '0; m_cnt = 0;
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        ex_ready = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; flush = 1'b0;
        @(posedge clk); #1;
        step();
        step();
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);

        // addi issues the cycle after acceptance
        rst_n = 1'b1; if_valid = 1'b1; if_instr = ADDI; if_pc = 32'h100;
        ex_ready = 1'b1;
        #1;
        chk("first_if_ready", {31'd0, if_ready}, 32'd1);
        step();
        if_instr = ADD; if_pc = 32'h104;
        #1;
        chk("addi_valid", {31'd0, id_valid}, 32'd1);
        chk("addi_imm", {27'd0, imm_sel}, 32'd1);
        chk("addi_rd", {27'd0, id_rd}, 32'd1);
        chk("addi_rs1", {27'd0, id_rs1}, 32'd0);
        step();

        // load-use on x2 for two cycles
        if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd2;
        #1;
        chk("luse_valid0", {31'd0, id_valid}, 32'd0);
        chk("luse_ready0", {31'd0, if_ready}, 32'd0);
        step();
        chk("luse_valid1", {31'd0, id_valid}, 32'd0);
        step();
        chk("luse_cnt", {16'd0, stall_cnt}, 32'd2);
        ex_mem_read = 1'b0; if_valid = 1'b1; if_instr = LUI; if_pc = 32'h108;
        #1;
        chk("luse_release", {31'd0, id_valid}, 32'd1);
        step();

        // lui reads no sources
        if_valid = 1'b0; ex_ready = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd0;
        #1;
        chk("lui_rd0_valid", {31'd0, id_valid}, 32'd1);
        chk("lui_imm", {27'd0, imm_sel}, 32'd5);
        ex_rd = 5'd1;
        #1;
        chk("lui_rd1_valid", {31'd0, id_valid}, 32'd1);
        step();

        // flush beats a simultaneous accept
        if_valid = 1'b1; if_instr = ADDI; if_pc = 32'h10C; ex_ready = 1'b1;
        ex_mem_read = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        #1;
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_instr", id_instr, 32'd0);
        chk("flush_cnt", {16'd0, stall_cnt}, 32'd2);

        // backpressure then streaming
        if_valid = 1'b1; if_instr = ADD; if_pc = 32'h200;
        step();
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_instr", id_instr, ADD);
            chk("bp_ready", {31'd0, if_ready}, 32'd0);
            step();
        end
        ex_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if_instr = ADDI | (32'(i + 1) << 7);
            if_pc = 32'h300 + 32'(4 * i);
            #1;
            chk("stream_valid", {31'd0, id_valid}, 32'd1);
            chk("stream_ready", {31'd0, if_ready}, 32'd1);
            step();
        end
        if_valid = 1'b0;
        step();

        for (int n = 0; n < 600; n++) begin
            rst_n       = ($urandom_range(0, 59) != 0);
            if_valid    = ($urandom_range(0, 3) != 0);
            if_instr    = rand_instr();
            if_pc       = $urandom;
            ex_ready    = ($urandom_range(0, 3) != 0);
            ex_mem_read = ($urandom_range(0, 1) != 0);
            ex_rd       = 5'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 15) == 0);
            step();
        end

        // saturation of the bubble counter
        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0;
        step();
        rst_n = 1'b1; if_valid = 1'b1; if_instr = ADD; if_pc = 32'h400;
        ex_ready = 1'b1;
        step();
        if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd1;
        quiet = 1'b1;
        for (int i = 0; i < 32'hFFFE; i++) step();
        quiet = 1'b0;
        chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
        chk("sat_held", {31'd0, id_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_issue_ctrl.md
ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 Parameter IMM_I_CODE, 5'd1, ex_op code for I-type immediate; set to match the shared header IMM_I value.
REQ-002 Parameters IMM_S_CODE 5'd2, IMM_B_CODE 5'd3, IMM_J_CODE 5'd4, IMM_U_CODE 5'd5, same rule; 5'd0 = no immediate.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 if_valid  in  1; if_instr  in  32; if_pc  in  32  — fetch-side offer.
REQ-006 if_ready  out  1  ID can accept this cycle.
REQ-007 ex_ready  in  1  EX accepts the ID instruction this cycle.
REQ-008 ex_mem_read  in  1; ex_rd  in  5  — instruction currently in EX is a load writing ex_rd.
REQ-009 flush  in  1  taken branch/jump redirect from EX.
REQ-010 id_valid  out  1; id_instr  out  32; id_pc  out  32  — issue to EX.
REQ-011 imm_sel  out  5  ex_op for the immediate generator.
REQ-012 id_rs1, id_rs2, id_rd  out  5 each  register fields of held instruction.
REQ-013 stall_cnt  out  16  saturating count of load-use bubble cycles.

Function
REQ-014 State SHALL be EMPTY or FULL; one instruction register (instr, pc).
REQ-015 if_ready SHALL = rst_n && (EMPTY || id_fire), id_fire = id_valid && ex_ready.
REQ-016 if_fire = if_valid && if_ready SHALL capture if_instr/if_pc next edge, state FULL.
REQ-017 id_fire without if_fire SHALL go FULL->EMPTY next edge; both together SHALL replace contents, remain FULL.
REQ-018 flush SHALL force EMPTY next edge, discarding held and any same-cycle if_fire instruction; flush overrides all.
REQ-019 Opcode [6:0] decode for imm_sel: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110111/0010111 -> U; others -> 0.
REQ-020 imm_sel, id_rs1 [19:15], id_rs2 [24:20], id_rd [11:7] SHALL derive combinationally from the held instr; all 0 when EMPTY.
REQ-021 rs1 used for I, R (0110011), S, B; rs2 used for R, S, B; none for U, J.
REQ-022 hazard SHALL = FULL && ex_mem_read && ex_rd!=0 && (used rs1==ex_rd || used rs2==ex_rd).
REQ-023 id_valid SHALL = FULL && !hazard && !flush; hazard holds instruction, lasts exactly as long as condition true.
REQ-024 stall_cnt SHALL increment each cycle hazard && !flush, saturate at 16'hFFFF, no wrap.
REQ-025 id_instr/id_pc SHALL be registered values, 0 when EMPTY; held stable while id_valid && !ex_ready.
REQ-026 Latency: instruction accepted at edge N SHALL present id_valid in cycle N+1 if no hazard/flush.

Reset
REQ-027 rst_n low at an edge SHALL set EMPTY, instr/pc 0, stall_cnt 0; outputs id_valid 0, if_ready 0, imm_sel 0, rs/rd 0.
REQ-028 Reset mid-operation SHALL discard held instruction; first if_fire possible first cycle rst_n high.

Verification
REQ-029 Reset, then if_instr 32'h00500093 (addi x1,x0,5), ex_ready 1 -> next cycle id_valid 1, imm_sel IMM_I_CODE, id_rd 1, id_rs1 0.
REQ-030 Hold 32'h002081B3 (add x3,x1,x2), ex_mem_read 1, ex_rd 2 for 2 cycles -> id_valid 0 both cycles, stall_cnt 2, if_ready 0; ex_mem_read 0 -> id_valid 1.
REQ-031 Hold 32'h123450B7 (lui x1), ex_mem_read 1, ex_rd 0 or 1 -> no hazard, id_valid 1, imm_sel IMM_U_CODE.
REQ-032 FULL with if_valid 1, ex_ready 1, flush 1 -> next cycle EMPTY, id_valid 0, stall_cnt unchanged.
REQ-033 ex_ready 0 for 3 cycles with FULL -> id_instr stable, if_ready 0; back-to-back stream with ex_ready 1 -> one issue per cycle.
REQ-034 Force stall_cnt to 16'hFFFE, 3 hazard cycles -> stall_cnt 16'hFFFF, holds.
